// File: rtl/mant_mul_pipe.sv
// Pipelined WIDTH x WIDTH unsigned mantissa multiplier, one SEG-bit slice of b per stage.
// Optional MUL_PIPE_FLUSH_EN adds a flush port that kills every in-flight product.
module mant_mul_pipe #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
`ifdef MUL_PIPE_FLUSH_EN
 ,input  logic               flush
`endif
);

  localparam int NSEG = WIDTH / SEG;
  localparam int PW   = 2 * WIDTH;

  logic [NSEG-1:0]  vld;
  logic [WIDTH-1:0] a_q   [NSEG-1];
  logic [WIDTH-1:0] b_q   [NSEG-1];
  logic [PW-1:0]    acc_q [NSEG];
  logic [PW-1:0]    acc_d [NSEG];
  logic             stall;
  logic             kill;

`ifdef MUL_PIPE_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign stall     = vld[NSEG-1] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = vld[NSEG-1];
  assign p         = acc_q[NSEG-1];

  // Stage k adds slice k of b, shifted into place, to the running sum.
  for (genvar k = 0; k < NSEG; k++) begin : g_pp
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [PW-1:0]    sacc;
    if (k == 0) begin : g_first
      assign sa   = a;
      assign sb   = b;
      assign sacc = '0;
    end else begin : g_rest
      assign sa   = a_q[k-1];
      assign sb   = b_q[k-1];
      assign sacc = acc_q[k-1];
    end
    assign acc_d[k] = sacc
      + (({{WIDTH{1'b0}}, sa} * PW'(sb[SEG*k +: SEG])) << (SEG*k));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < NSEG; k++) acc_q[k] <= '0;
      for (int k = 0; k < NSEG-1; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      if (kill)        vld <= '0;
      else if (!stall) vld <= {vld[NSEG-2:0], in_valid};
      // Datapath shifts on every unstalled edge; flush only touches valids.
      if (!stall) begin
        for (int k = 0; k < NSEG; k++) acc_q[k] <= acc_d[k];
        a_q[0] <= a;
        b_q[0] <= b;
        for (int k = 1; k < NSEG-1; k++) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_mant_mul_pipe.sv
// Self-checking bench for mant_mul_pipe: directed corners plus randomized
// valid/ready traffic against a queue-based exact-multiply reference.
module tb_mant_mul_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [63:0]  a = '0;
  logic [63:0]  b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] p;
`ifdef MUL_PIPE_FLUSH_EN
  logic         flush = 1'b0;
`endif

  int checks = 0;
  int passes = 0;

  mant_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
`ifdef MUL_PIPE_FLUSH_EN
   ,.flush     (flush)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_mul(logic [63:0] x, logic [63:0] y);
    return {64'd0, x} * {64'd0, y};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = pick();
      b = pick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || p !== '0)
        $display("FAIL reset_hold: out_valid=%b p=%h want 0/0", out_valid, p);
      else passes++;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0)
        $display("FAIL reset_quiet: out_valid=%b want 0", out_valid);
      else passes++;
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    a = 64'd3;
    b = 64'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4)
      $display("FAIL basic_latency: got %0d want 4", lat);
    else passes++;
    checks++;
    if (p !== 128'd15)
      $display("FAIL basic_product: got %h want 15", p);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL basic_single: out_valid=%b want 0", out_valid);
    else passes++;
  endtask

  task automatic test_corner();
    logic [127:0] exp [3];
    logic [63:0]  ca  [3];
    logic [63:0]  cb  [3];
    int got = 0;
    ca[0] = '1;  cb[0] = '1;
    ca[1] = '0;  cb[1] = {$urandom(), $urandom()};
    ca[2] = 64'h8000_0000_0000_0000;
    cb[2] = 64'h8000_0000_0000_0000;
    exp[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    exp[1] = '0;
    exp[2] = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 3);
      if (c < 3) begin
        a = ca[c];
        b = cb[c];
      end
      if (out_valid) begin
        checks++;
        if (got > 2)
          $display("FAIL corner_extra: unexpected p=%h", p);
        else if (p !== exp[got])
          $display("FAIL corner_%0d: got %h want %h", got, p, exp[got]);
        else passes++;
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 3)
      $display("FAIL corner_count: got %0d want 3", got);
    else passes++;
  endtask

  task automatic test_stream();
    int got = 0;
    int first = -1;
    int last = -1;
    logic [127:0] exp;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 8);
      a = 64'(c + 1);
      b = 64'(c + 2);
      if (out_valid) begin
        exp = 128'((got + 1) * (got + 2));
        checks++;
        if (p !== exp)
          $display("FAIL stream_%0d: got %0d want %0d", got, p, exp);
        else passes++;
        if (first < 0) first = c;
        last = c;
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 8 || last - first !== 7)
      $display("FAIL stream_count: got %0d over span %0d want 8 over 7",
               got, last - first);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [127:0] q [$];
    logic [127:0] held = '0;
    logic         was_stall = 1'b0;
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid  = (sent < 12);
      out_ready = !(c >= 5 && c < 10);
      a = pick();
      b = pick();
      #1;
      if (c >= 5 && c < 10) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
          $display("FAIL bp_stall: in_ready=%b out_valid=%b want 0/1",
                   in_ready, out_valid);
        else passes++;
      end
      if (was_stall) begin
        checks++;
        if (p !== held)
          $display("FAIL bp_hold: got %h want %h", p, held);
        else passes++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0)
          $display("FAIL bp_spurious: p=%h with nothing pending", p);
        else if (p !== q[0])
          $display("FAIL bp_data: got %h want %h", p, q[0]);
        else passes++;
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      was_stall = out_valid && !out_ready;
      held = p;
      if (in_valid && in_ready) begin
        q.push_back(ref_mul(a, b));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 12 || q.size() !== 0)
      $display("FAIL bp_count: got %0d left %0d want 12/0", got, q.size());
    else passes++;
  endtask

  task automatic test_random();
    logic [127:0] q [$];
    logic [127:0] held = '0;
    logic         was_stall = 1'b0;
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = (c < 360) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = pick();
      b = pick();
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        $display("FAIL rnd_in_ready: got %b at cycle %0d", in_ready, c);
        errs++;
      end else passes++;
      if (was_stall) begin
        checks++;
        if (p !== held || out_valid !== 1'b1)
          $display("FAIL rnd_hold: got %h/%b want %h/1", p, out_valid, held);
        else passes++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0)
          $display("FAIL rnd_spurious: p=%h with nothing pending", p);
        else if (p !== q[0])
          $display("FAIL rnd_data: got %h want %h", p, q[0]);
        else passes++;
        if (q.size() != 0) void'(q.pop_front());
      end
      was_stall = out_valid && !out_ready;
      held = p;
      if (in_valid && in_ready) q.push_back(ref_mul(a, b));
      tick();
      if (errs > 5) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (q.size() !== 0)
      $display("FAIL rnd_drain: %0d products never emitted", q.size());
    else passes++;
  endtask

  task automatic seven_nine(input string tag);
    int lat;
    a = 64'd7;
    b = 64'd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4 || p !== 128'd63)
      $display("FAIL %s_after: lat %0d p %0d want 4/63", tag, lat, p);
    else passes++;
    tick();
  endtask

  task automatic test_midop_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a = pick();
      b = 64'd1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid !== 1'b0)
        $display("FAIL midrst_leak: out_valid=%b p=%h", out_valid, p);
      else passes++;
      tick();
    end
    seven_nine("midrst");
  endtask

`ifdef MUL_PIPE_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a = pick();
      b = 64'd3;
      tick();
    end
    // This beat coincides with flush and must be dropped too.
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL flush_in_ready: got %b want 1", in_ready);
    else passes++;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid !== 1'b0)
        $display("FAIL flush_leak: out_valid=%b p=%h", out_valid, p);
      else passes++;
      tick();
    end
    seven_nine("flush");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corner();
    test_stream();
    test_backpressure();
    test_random();
    test_midop_reset();
`ifdef MUL_PIPE_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
